// File: rtl/bmp_frame_ctrl.sv
// BMP frame export sequencer: runs the header writer, then streams padded pixel rows into memory.
// Optional feature macro: BMP_BOTTOM_UP_EN (bottom-up row ordering when defined).
module bmp_frame_ctrl #(
    parameter int HDR_BYTES = 54,
    parameter int ADDR_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [10:0]       xMin,
    input  logic [10:0]       xMax,
    input  logic [10:0]       yMin,
    input  logic [10:0]       yMax,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              hdr_start,
    input  logic              hdr_done,
    input  logic [ADDR_W-1:0] hdr_addr,
    input  logic              hdr_wren,
    input  logic [15:0]       hdr_wrdata,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_data,
    output logic [ADDR_W-1:0] addr,
    output logic              wren,
    output logic [15:0]       wrdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HDR_START = 3'd1;
    localparam logic [2:0] S_HDR_WAIT  = 3'd2;
    localparam logic [2:0] S_PIX       = 3'd3;
    localparam logic [2:0] S_PAD       = 3'd4;
    localparam logic [2:0] S_ROW_END   = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]        state;
    logic [10:0]       x_min_q, x_max_q, y_min_q, y_max_q;
    logic [11:0]       row;
    logic [13:0]       col;
    logic              err_q;

    logic [11:0]       w, h, row_idx;
    logic [13:0]       rb, stride;
    logic [1:0]        pad;
    logic [ADDR_W-1:0] row_base, cur_addr;
    logic              bad_bounds;

    // Row geometry derives from the latched window; col runs across data and pad bytes alike.
    always_comb begin
        w        = {1'b0, x_max_q - x_min_q} + 12'd1;
        h        = {1'b0, y_max_q - y_min_q} + 12'd1;
        rb       = 14'(w) * 14'd3;
        pad      = 2'd0 - rb[1:0];
        stride   = rb + {12'd0, pad};
`ifdef BMP_BOTTOM_UP_EN
        row_idx  = h - 12'd1 - row;
`else
        row_idx  = row;
`endif
        row_base = ADDR_W'(HDR_BYTES) + ADDR_W'(row_idx) * ADDR_W'(stride);
        cur_addr = row_base + ADDR_W'(col);
    end

    assign bad_bounds = (xMax < xMin) || (yMax < yMin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            x_min_q <= '0;
            x_max_q <= '0;
            y_min_q <= '0;
            y_max_q <= '0;
            row     <= '0;
            col     <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        x_min_q <= xMin;
                        x_max_q <= xMax;
                        y_min_q <= yMin;
                        y_max_q <= yMax;
                        if (bad_bounds) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err_q <= 1'b0;
                            row   <= '0;
                            col   <= '0;
                            state <= S_HDR_START;
                        end
                    end
                end
                S_HDR_START: state <= S_HDR_WAIT;
                S_HDR_WAIT: begin
                    if (hdr_done) state <= S_PIX;
                end
                S_PIX: begin
                    if (pix_valid) begin
                        col <= col + 14'd1;
                        if (col == rb - 14'd1) state <= (pad != 2'd0) ? S_PAD : S_ROW_END;
                    end
                end
                S_PAD: begin
                    col <= col + 14'd1;
                    if (col == stride - 14'd1) state <= S_ROW_END;
                end
                S_ROW_END: begin
                    col <= '0;
                    row <= row + 12'd1;
                    state <= (row + 12'd1 == h) ? S_DONE : S_PIX;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The header writer owns the memory port only while we wait on it.
    always_comb begin
        addr   = '0;
        wren   = 1'b0;
        wrdata = '0;
        case (state)
            S_HDR_WAIT: begin
                addr   = hdr_addr;
                wren   = hdr_wren;
                wrdata = hdr_wrdata;
            end
            S_PIX: begin
                addr   = cur_addr;
                wren   = pix_valid;
                wrdata = {8'h00, pix_data};
            end
            S_PAD: begin
                addr   = cur_addr;
                wren   = 1'b1;
            end
            default: ;
        endcase
    end

    assign done      = (state == S_DONE);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign err       = err_q;
    assign hdr_start = (state == S_HDR_START);
    assign pix_ready = (state == S_PIX);

endmodule

// File: doc/bmp_frame_ctrl.md
# bmp_frame_ctrl

Sequencer for BMP frame export to the shared framebuffer memory write port. On `start` it latches the crop window, kicks the BMP header writer and passes its memory port through until `hdr_done`. It then streams pixel bytes from the pixel source into memory after the 54-byte header, inserting zero padding so every row is a multiple of 4 bytes. It owns the single memory write port and is the only block driving `addr`/`wren`/`wrdata`.

## Interface
- `HDR_BYTES`, 54: byte address of the first pixel byte.
- `ADDR_W`, 24: memory address width.
- `clk` in 1: the single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a frame; sampled only in IDLE or DONE.
- `xMin`, `xMax`, `yMin`, `yMax` in 11 each: crop window, inclusive bounds, latched at accepted `start`.
- `done` out 1: frame complete; held until the next accepted `start`.
- `busy` out 1: high in every state except IDLE and DONE.
- `err` out 1: bounds invalid for the last accepted `start`; valid while `done`=1.
- `hdr_start` out 1: one-cycle pulse to the header writer.
- `hdr_done` in 1: header writer finished.
- `hdr_addr` in ADDR_W, `hdr_wren` in 1, `hdr_wrdata` in 16: header writer memory port.
- `pix_valid` in 1, `pix_ready` out 1, `pix_data` in 8: pixel byte stream, B,G,R per pixel, left to right, rows in order yMin..yMax.
- `addr` out ADDR_W, `wren` out 1, `wrdata` out 16: memory write port; one byte per write in `wrdata[7:0]`, with `[15:8]`=0 for pixel and pad writes.

## Operation
- Latched at `start`: W = xMax-xMin+1 and H = yMax-yMin+1, both 12 bits.
  - RB = 3W (14 bits).
  - PAD = (4 - RB mod 4) mod 4.
  - STRIDE = RB+PAD.
  - Row base = HDR_BYTES + rowidx*STRIDE, computed at ADDR_W width with no overflow for the 2048x2048 maximum.
- States: IDLE, HDR_START, HDR_WAIT, PIX, PAD, ROW_END, DONE.
- IDLE/DONE + `start`:
  - If xMax<xMin or yMax<yMin, go to DONE with `err`=1. No `hdr_start` pulse and no writes.
  - Otherwise clear `err`, `done`, row and column counters, then go to HDR_START.
- HDR_START: `hdr_start`=1 for exactly one cycle, then go to HDR_WAIT.
- HDR_WAIT:
  - `addr`/`wren`/`wrdata` = `hdr_*`, combinational pass-through.
  - When `hdr_done`=1, go to PIX. The write presented in the `hdr_done` cycle is still passed through.
- PIX:
  - `pix_ready`=1. Each `pix_valid`&`pix_ready` cycle writes `wren`=1, `addr`=rowbase+col, `wrdata`={8'h00,`pix_data`}, then col++.
  - On the accept with col=RB-1: go to PAD if PAD>0, else ROW_END.
- PAD: `pix_ready`=0. Writes `wrdata`=0 at rowbase+RB+k for k=0..PAD-1, one per cycle, then go to ROW_END.
- ROW_END: no write; col=0, row++. If row=H go to DONE, else go to PIX.
- DONE: `done`=1, no writes.
- `hdr_*` inputs are ignored outside HDR_WAIT. `hdr_done` is ignored outside HDR_WAIT.
- `start` while `busy` is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `done`, `busy`, `err`, `hdr_start`, `pix_ready`, `wren` = 0.
  - `addr` = 0, `wrdata` = 0.
  - All counters and latched bounds = 0.
- `rst` asserted mid-frame: the very next output is the reset value (async). No partial write completes after `rst` rises.
- Memory outputs are combinational from registered state. A pixel write occurs in the same cycle as its handshake, with zero latency.
- `start` accepted at edge n:
  - `hdr_start`=1 in cycle n+1.
  - HDR_WAIT from cycle n+2.
- `hdr_done` sampled at edge m: first `pix_ready`=1 in cycle m+1.
- Bad bounds: `done`=`err`=1 in the cycle after `start`.
- Row overhead: PAD cycles plus 1 ROW_END cycle.
- Frame length after `hdr_done`, with no `pix_valid` gaps: H*(RB+PAD+1) cycles.
- `pix_valid` low in PIX: no write, counters hold. The stall may last any number of cycles.
- W=1, H=1 is legal: 3 pixel writes, 1 pad write, then DONE.

## Configuration
- `BMP_BOTTOM_UP_EN` defined: rowidx = H-1-row. The first streamed row is written at the highest row base, giving native bottom-up BMP ordering.
- `BMP_BOTTOM_UP_EN` undefined: rowidx = row, top-down ordering.
- All other behaviour is identical in both configurations.

## Test plan
- Window 0..3 x 0..1, macro off, `pix_valid` always 1, header writer model asserting `hdr_done`:
  - One `hdr_start` pulse.
  - 24 writes at addr 54..77 carrying the streamed bytes, no pad writes.
  - `done`=1 with `err`=0.
- Window 5..5 x 7..8, macro off: data writes at 54,55,56, pad write 0 at 57, data writes at 58,59,60, pad write 0 at 61, then `done`.
- Same window, macro on: first row written at 58..61, second row at 54..57.
- xMin=10, xMax=9: `done`=`err`=1 the cycle after `start`; no `hdr_start` and no `wren` at any point.
- Toggle `pix_valid` randomly, and drive `hdr_wren`=1 during PIX:
  - Write addresses stay contiguous per row.
  - Bytes are neither skipped nor duplicated.
  - The header port never reaches the outputs.
- Assert `rst` after the 5th pixel write:
  - Outputs return to reset values immediately and `busy`=0.
  - A subsequent `start` rewrites the frame from addr 54.
  - Also check: a `start` pulse given mid-frame is ignored.
